// File: rtl/input_event_pkg.sv
// Shared event-code constants for the input event encoder and the virtual_input decoder.
package input_event_pkg;

    localparam int NUM_SW  = 18;
    localparam int NUM_KEY = 3;
    localparam int NUM_EV  = NUM_SW + NUM_KEY;
    localparam int CODE_W  = 5;
    localparam int GAP_W   = 4;

    localparam logic [CODE_W-1:0] CODE_CHANGE = 5'd20;
    localparam logic [CODE_W-1:0] CODE_ENTER  = 5'd21;
    localparam logic [CODE_W-1:0] CODE_CANCEL = 5'd22;

    localparam int KEY_CHANGE = 0;
    localparam int KEY_ENTER  = 1;
    localparam int KEY_CANCEL = 2;

    localparam logic [NUM_EV-1:0] EV_ONE = NUM_EV'(1);

    // Bitmap layout: [17:0] switches, [18] change, [19] enter, [20] cancel.
    function automatic logic [NUM_EV-1:0] code_to_mask(input logic [CODE_W-1:0] code);
        logic [NUM_EV-1:0] m;
        m = '0;
        if (code < CODE_W'(NUM_SW)) begin
            m = EV_ONE << code;
        end else if (code >= CODE_CHANGE && code <= CODE_CANCEL) begin
            m = EV_ONE << (code - 5'd2);
        end
        return m;
    endfunction

endpackage

// File: rtl/event_priority_pick.sv
// Combinational picker: highest-priority pending event (cancel, enter, change, lowest switch).
module event_priority_pick
    import input_event_pkg::*;
(
    input  logic [NUM_EV-1:0] pending,
    output logic              valid,
    output logic [CODE_W-1:0] code
);

    always_comb begin
        valid = |pending;
        code  = '0;
        if (pending[NUM_SW+KEY_CANCEL]) begin
            code = CODE_CANCEL;
        end else if (pending[NUM_SW+KEY_ENTER]) begin
            code = CODE_ENTER;
        end else if (pending[NUM_SW+KEY_CHANGE]) begin
            code = CODE_CHANGE;
        end else begin
            // Scan downward so the lowest-numbered pending switch wins.
            for (int i = NUM_SW - 1; i >= 0; i--) begin
                if (pending[i]) begin
                    code = CODE_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/input_event_encoder.sv
// Turns switch toggles and button presses into paced one-cycle event strobes.
// Define INPUT_EVENT_ENCODER_SYNC_EN to add two-flop synchronizers on sw and key.
module input_event_encoder
    import input_event_pkg::*;
#(
    parameter int GAP = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw,
    input  logic [NUM_KEY-1:0] key,
    output logic [CODE_W-1:0] number,
    output logic              control,
    output logic              busy
);

    localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(GAP);

    logic [NUM_SW-1:0]  sw_in;
    logic [NUM_KEY-1:0] key_in;

`ifdef INPUT_EVENT_ENCODER_SYNC_EN
    logic [NUM_SW-1:0]  sw_s1_q, sw_s2_q;
    logic [NUM_KEY-1:0] key_s1_q, key_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q  <= sw;
            sw_s2_q  <= sw;
            key_s1_q <= key;
            key_s2_q <= key;
        end else begin
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= key;
            key_s2_q <= key_s1_q;
        end
    end

    assign sw_in  = sw_s2_q;
    assign key_in = key_s2_q;
`else
    assign sw_in  = sw;
    assign key_in = key;
`endif

    logic [NUM_SW-1:0]  sw_smp_q, sw_smp_d;
    logic [NUM_KEY-1:0] key_smp_q, key_smp_d;
    logic [NUM_EV-1:0]  pend_q, pend_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               control_q, control_d;
    logic [CODE_W-1:0]  number_q, number_d;

    logic               pick_valid;
    logic [CODE_W-1:0]  pick_code;
    logic               emit;
    logic [NUM_EV-1:0]  clr_mask;
    logic [NUM_EV-1:0]  pend_kept;
    logic [NUM_SW-1:0]  sw_tgl;
    logic [NUM_KEY-1:0] key_rise;

    event_priority_pick u_pick (
        .pending (pend_q),
        .valid   (pick_valid),
        .code    (pick_code)
    );

    always_comb begin
        sw_smp_d  = sw_in;
        key_smp_d = key_in;
        sw_tgl    = sw_in ^ sw_smp_q;
        key_rise  = key_in & ~key_smp_q;

        emit      = pick_valid && !control_q && (gap_q == '0);
        clr_mask  = emit ? code_to_mask(pick_code) : '0;
        pend_kept = pend_q & ~clr_mask;

        // Clear first, then apply new requests, so a same-cycle request survives.
        pend_d[NUM_SW-1:0]      = pend_kept[NUM_SW-1:0] ^ sw_tgl;
        pend_d[NUM_EV-1:NUM_SW] = pend_kept[NUM_EV-1:NUM_SW] | key_rise;

        // Receiver zeroes its switch image on cancel; replay every switch that is high.
        if (emit && pick_code == CODE_CANCEL) begin
            pend_d[NUM_SW-1:0] = sw_in;
        end

        gap_d = gap_q;
        if (emit) begin
            gap_d = GAP_LD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end

        control_d = emit;
        number_d  = emit ? pick_code : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_smp_q  <= sw;
            key_smp_q <= key;
            pend_q    <= '0;
            gap_q     <= '0;
            control_q <= 1'b0;
            number_q  <= '0;
        end else begin
            sw_smp_q  <= sw_smp_d;
            key_smp_q <= key_smp_d;
            pend_q    <= pend_d;
            gap_q     <= gap_d;
            control_q <= control_d;
            number_q  <= number_d;
        end
    end

    assign control = control_q;
    assign number  = number_q;
    assign busy    = (|pend_q) || (gap_q != '0);

endmodule
